// File: rtl/uart_tx_out_if.sv
// CPU store-path bus into the serial output port: address, store enable and
// store data in, status byte back out for the load mux.
interface uart_tx_out_if;
  logic [7:0] Address;
  logic       we;
  logic [7:0] RegData;
  logic [7:0] StatusData;

  modport master (output Address, output we, output RegData, input StatusData);
  modport slave  (input Address, input we, input RegData, output StatusData);
endinterface

// File: rtl/uart_tx_out.sv
// Memory-mapped 8N1 UART transmitter for the single-cycle CPU: stores to
// TX_ADDR queue a byte in a small FIFO, and the status byte reports FIFO and line state.
module uart_tx_out #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  TX_ADDR      = 8'hFD,
  parameter logic [7:0]  STATUS_ADDR  = 8'hFC,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_out_if.slave bus,
  output logic         UART_TXD,
  output logic         tx_busy
);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e            state, state_next;
  logic              hit_tx, hit_st, hit_tx_q, hit_st_q;
  logic              push_req, clr_req, push, pop, ovf_set;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full, empty, overflow;
  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic              baud_last;
  logic [2:0]        bit_idx, bit_idx_next;
  logic [7:0]        shift, shift_next;
  logic              txd_next;
  logic [2:0]        count3;

  // The CPU holds a store for many clocks; only its first clock acts.
  assign hit_tx   = bus.we && (bus.Address == TX_ADDR);
  assign hit_st   = bus.we && (bus.Address == STATUS_ADDR);
  assign push_req = hit_tx && !hit_tx_q;
  assign clr_req  = hit_st && !hit_st_q;

  // Sampled through reset too, so a store still held when reset drops is not seen as new.
  always_ff @(posedge clk) begin
    hit_tx_q <= hit_tx;
    hit_st_q <= hit_st;
  end

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign baud_last = (baud_cnt == BAUD_LAST);
  assign push      = push_req && (!full || pop);
  assign ovf_set   = push_req && full && !pop;
  assign tx_busy   = (state != IDLE);
  assign count3    = 3'(count);
  assign bus.StatusData = {1'b0, count3, overflow, empty, full, tx_busy};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!empty) state_next = START;
      START:   if (baud_last) state_next = DATA;
      DATA:    if (baud_last && bit_idx == 3'd7) state_next = STOP;
      STOP:    if (baud_last) state_next = empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    pop          = 1'b0;
    baud_next    = '0;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    if (state != IDLE) baud_next = baud_last ? '0 : baud_cnt + 1'b1;
    if ((state == IDLE || (state == STOP && baud_last)) && !empty) begin
      pop          = 1'b1;
      shift_next   = mem[rd_ptr];
      bit_idx_next = '0;
    end else if (state == DATA && baud_last) begin
      shift_next   = shift >> 1;
      bit_idx_next = bit_idx + 3'd1;
    end
    // The line is registered from the upcoming state, so it changes exactly on state edges.
    unique case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      default: txd_next = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      UART_TXD <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      baud_cnt <= baud_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
      UART_TXD <= txd_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // A new overflow wins over a clear in the same clock.
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_req) overflow <= 1'b0;
    end
  end

  // NOTE: FIFO storage is not reset; count guarantees stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.RegData;
  end
endmodule

// File: doc/uart_tx_out.md
Name: uart_tx_out

Overview:
- Memory-mapped serial output port for the 8-bit single-cycle CPU.
- Sits downstream of the datapath store path, alongside the parallel output port. It consumes the ALU result (address), the store write-enable and the register data of a store instruction.
- Queues bytes in a small FIFO and drives them out on UART_TXD as 8N1 frames.
- Exposes a status byte that the parallel input mux can return on loads.

Parameters:
- CLKS_PER_BIT, 434: clk cycles per serial bit (50 MHz / 115200 baud).
- TX_ADDR, 8'hFD: store address that enqueues a byte.
- STATUS_ADDR, 8'hFC: address of the status byte; a store to it clears the overflow flag.
- FIFO_DEPTH, 4: FIFO entries; must be a power of 2.

Ports:
- clk  input  1  system clock (CLOCK_50 domain); one clock only.
- rst  input  1  synchronous, active-high reset.
- Address  input  8  ALU result / data address from the CPU.
- we  input  1  CPU store enable, held as a level for a whole (slow) CPU cycle.
- RegData  input  8  store data (rd2).
- UART_TXD  output  1  serial line; idles high.
- StatusData  output  8  status byte: {1'b0, count[2:0], overflow, empty, full, busy}.
- tx_busy  output  1  high while a frame is being shifted out.

Behaviour:
- Reset is synchronous on rst=1 at a clk edge. Afterwards:
  - UART_TXD=1, tx_busy=0, FIFO empty (count=0), overflow=0.
  - FSM=IDLE; StatusData=8'h04.
- Reset mid-frame aborts the frame: UART_TXD returns to 1 after that edge and the FIFO contents are discarded.
- Write detection:
  - hit_tx = we & (Address==TX_ADDR); hit_st = we & (Address==STATUS_ADDR).
  - Both are registered every cycle. Action is taken only on a rising edge (hit & ~hit_q), so a long CPU store pushes exactly once.
- Push: on a rising edge of hit_tx, RegData is written at the FIFO tail.
  - If FIFO is full and no pop occurs that cycle, the byte is dropped and overflow is set (sticky).
  - Rising edge of hit_st clears overflow. If a new overflow occurs in the same cycle, set wins.
- Pop occurs in IDLE when FIFO is non-empty, and in STOP's last cycle when FIFO is non-empty.
- Simultaneous push and pop: both are performed and count is unchanged. A push while full is accepted if a pop occurs that cycle.
- Count width is 3 bits (0..4). full = (count==FIFO_DEPTH); empty = (count==0). Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: UART_TXD=1. If not empty: pop into shift register, bit_idx=0, baud counter=0, go to START.
  - START: UART_TXD=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: UART_TXD=shift[0], LSB first. After each CLKS_PER_BIT cycles, shift right and increment bit_idx. After bit 7, go to STOP.
  - STOP: UART_TXD=1 for CLKS_PER_BIT cycles. On the last cycle: if not empty, pop and go to START (no idle gap); else go to IDLE.
- Latency: if a push takes effect at edge k with FSM in IDLE, the pop happens at edge k+1 and UART_TXD=0 from edge k+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- tx_busy = (FSM != IDLE). The busy bit in StatusData equals tx_busy.
- The baud counter runs 0..CLKS_PER_BIT-1 and is held at 0 in IDLE.
- Address values matching neither TX_ADDR nor STATUS_ADDR are ignored.
- UART_TXD is registered (no glitches).

Test Plan:
- Reset and idle check (CLKS_PER_BIT=4 for all tests):
  - Stimulus: rst=1 for 2 cycles, then release.
  - Required: UART_TXD=1, tx_busy=0, StatusData=8'h04.
- Single byte:
  - Stimulus: Address=8'hFD, we=1 held for 20 cycles, RegData=8'h55.
  - Required: exactly one frame; UART_TXD reads 0,1,0,1,0,1,0,1,0,1 with 4 cycles per bit. Start bit begins 1 cycle after the push edge. Count returns to 0 and tx_busy falls after 40 cycles.
- Back-to-back:
  - Stimulus: push 8'hA3 then 8'h0F (separate we pulses) during the first frame.
  - Required: second start bit immediately follows the first stop bit. Total busy time is 80 cycles. Bits of 0xA3 appear LSB first: 1,1,0,0,0,1,0,1.
- Full / overflow:
  - Stimulus: push 6 bytes quickly.
  - Required: first byte goes to the shifter, next 4 fill the FIFO (full=1, StatusData[6:4]=4), 6th byte is dropped, overflow=1.
  - Follow-up: store to 8'hFC clears overflow. The dropped byte is never transmitted.
- Simultaneous push/pop and wrap:
  - Stimulus: push timed on the STOP last cycle while the FIFO holds 4.
  - Required: count stays 4 and no overflow. After >8 total pushes, bytes still emerge in order (pointer wrap).
- Reset mid-frame:
  - Stimulus: assert rst during DATA bit 3 with 2 bytes queued.
  - Required: UART_TXD=1 on the next edge, StatusData=8'h04, no further frames.
